// File: rtl/chrono_pkg.sv
// Shared definitions for the BCD chronometer core.
//   MODE_SW / MODE_TMR : mode encoding (stopwatch / countdown timer)
//   lim()              : highest legal value of digit i (LSD = index 0)
//   clamp_bcd()        : saturate one BCD digit to its limit
//   sec_ones_idx() / min_ones_idx() : digit positions of the seconds-ones
//                        and minute-ones digits for a given fraction width
package chrono_pkg;

   localparam logic MODE_SW  = 1'b0;
   localparam logic MODE_TMR = 1'b1;

   function automatic int sec_ones_idx(input int frac_digits);
      return frac_digits;
   endfunction

   function automatic int min_ones_idx(input int frac_digits);
      return frac_digits + 2;
   endfunction

   // Seconds-tens sits directly above seconds-ones and only counts 0..5.
   function automatic logic [3:0] lim(input int i, input int frac_digits);
      return (i == frac_digits + 1) ? 4'd5 : 4'd9;
   endfunction

   function automatic logic [3:0] clamp_bcd(input logic [3:0] d, input logic [3:0] l);
      return (d > l) ? l : d;
   endfunction

endpackage

// File: rtl/chrono_scan.sv
// Seven-segment scan multiplexer: walks one active-low anode per slot,
// presenting that slot's BCD digit and decimal point on registered outputs.
//   clk, rst_n : clock, async active-low reset
//   disp       : ND packed BCD digits, LSD at [3:0]
//   an         : active-low anode select (one-cold)
//   digit_bcd  : digit for the active anode
//   dp         : active-low decimal point for the active anode
module chrono_scan
   import chrono_pkg::*;
#(
   parameter int ND          = 5,
   parameter int SCAN_DIV    = 100_000,
   parameter int FRAC_DIGITS = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [4*ND-1:0] disp,
   output logic [ND-1:0]   an,
   output logic [3:0]      digit_bcd,
   output logic            dp
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int SW = (ND > 1) ? $clog2(ND) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [SW-1:0] SLOT_LAST = SW'(ND - 1);
   localparam logic [SW-1:0] SEC_SLOT  = SW'(sec_ones_idx(FRAC_DIGITS));
   localparam logic [SW-1:0] MIN_SLOT  = SW'(min_ones_idx(FRAC_DIGITS));

   logic [CW-1:0] scan_cnt;
   logic [SW-1:0] slot;
   logic [3:0]    digit_sel;
   logic [ND-1:0] an_sel;
   logic          dp_sel;

   always_comb begin
      digit_sel = '0;
      an_sel    = '1;
      for (int i = 0; i < ND; i++) begin
         if (slot == SW'(i)) begin
            digit_sel = disp[4*i +: 4];
            an_sel[i] = 1'b0;
         end
      end
      // Decimal point marks the seconds/fraction split and the M:SS separator.
      dp_sel = ~(((FRAC_DIGITS > 0) && (slot == SEC_SLOT)) || (slot == MIN_SLOT));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt  <= '0;
         slot      <= '0;
         an        <= '1;
         digit_bcd <= '0;
         dp        <= 1'b1;
      end else begin
         if (scan_cnt == CNT_LAST) begin
            scan_cnt <= '0;
            slot     <= (slot == SLOT_LAST) ? '0 : slot + 1'b1;
         end else begin
            scan_cnt <= scan_cnt + 1'b1;
         end
         an        <= an_sel;
         digit_bcd <= digit_sel;
         dp        <= dp_sel;
      end
   end

endmodule

// File: rtl/bcd_chrono_core.sv
// Stopwatch / countdown timer core with BCD count M..M:SS[.F..F], lap hold,
// load clamping and a built-in display scan multiplexer.
//   clk, rst_n                 : clock, async active-low reset
//   start_stop/lap/mode/load/clear : one-cycle command pulses
//   load_value                 : BCD preset (timer mode, stopped)
//   count_bcd                  : live count, LSD at [3:0]
//   running, mode_out, lap_hold: status
//   done, wrap                 : one-cycle event pulses
//   an, digit_bcd, dp          : scanned display outputs
//
// Control state (running, mode_out):
//   state      | meaning
//   0,MODE_SW  | stopwatch idle
//   1,MODE_SW  | stopwatch counting up, wraps at max
//   0,MODE_TMR | timer idle, loadable
//   1,MODE_TMR | timer counting down, stops itself at zero
module bcd_chrono_core
   import chrono_pkg::*;
#(
   parameter int CLK_HZ      = 100_000_000,
   parameter int TICK_HZ     = 100,
   parameter int FRAC_DIGITS = 2,
   parameter int MIN_DIGITS  = 2,
   parameter int SCAN_DIV    = 100_000
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               start_stop,
   input  logic                               lap,
   input  logic                               mode,
   input  logic                               load,
   input  logic                               clear,
   input  logic [4*(FRAC_DIGITS+2+MIN_DIGITS)-1:0] load_value,
   output logic [4*(FRAC_DIGITS+2+MIN_DIGITS)-1:0] count_bcd,
   output logic                               running,
   output logic                               mode_out,
   output logic                               lap_hold,
   output logic                               done,
   output logic                               wrap,
   output logic [FRAC_DIGITS+2+MIN_DIGITS-1:0] an,
   output logic [3:0]                         digit_bcd,
   output logic                               dp
);

   localparam int ND  = FRAC_DIGITS + 2 + MIN_DIGITS;
   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = $clog2(DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

   logic [PW-1:0]   presc;
   logic            tick;
   logic [4*ND-1:0] lap_reg;
   logic [4*ND-1:0] inc_v, dec_v, ld_clamp, disp;
   logic            carry, borrow, is_zero;

   logic [4*ND-1:0] count_n, lap_n;
   logic            running_n, mode_n, lap_hold_n, done_n, wrap_n;

   // Prescaler is held at zero while stopped so the first tick lands
   // exactly DIV cycles after running rises.
   assign tick = running && (presc == PRE_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         presc <= '0;
      else if (!running || presc == PRE_LAST)
         presc <= '0;
      else
         presc <= presc + 1'b1;
   end

   always_comb begin
      inc_v    = count_bcd;
      dec_v    = count_bcd;
      ld_clamp = '0;
      carry    = 1'b1;
      borrow   = 1'b1;
      for (int i = 0; i < ND; i++) begin
         if (carry) begin
            if (count_bcd[4*i +: 4] == lim(i, FRAC_DIGITS)) begin
               inc_v[4*i +: 4] = 4'd0;
            end else begin
               inc_v[4*i +: 4] = count_bcd[4*i +: 4] + 4'd1;
               carry = 1'b0;
            end
         end
         if (borrow) begin
            if (count_bcd[4*i +: 4] == 4'd0) begin
               dec_v[4*i +: 4] = lim(i, FRAC_DIGITS);
            end else begin
               dec_v[4*i +: 4] = count_bcd[4*i +: 4] - 4'd1;
               borrow = 1'b0;
            end
         end
         ld_clamp[4*i +: 4] = clamp_bcd(load_value[4*i +: 4], lim(i, FRAC_DIGITS));
      end
      is_zero = (count_bcd == '0);
   end

   // Only the highest-priority pulse acts; a tick rides along unless the
   // cycle carries clear or load.
   always_comb begin
      count_n    = count_bcd;
      lap_n      = lap_reg;
      running_n  = running;
      mode_n     = mode_out;
      lap_hold_n = lap_hold;
      done_n     = 1'b0;
      wrap_n     = 1'b0;
      if (clear) begin
         count_n    = '0;
         running_n  = 1'b0;
         lap_hold_n = 1'b0;
      end else if (load) begin
         if (mode_out == MODE_TMR && !running)
            count_n = ld_clamp;
      end else begin
         if (mode) begin
            if (!running) begin
               mode_n     = ~mode_out;
               lap_hold_n = 1'b0;
            end
         end else if (start_stop) begin
            if (running || mode_out == MODE_SW || !is_zero)
               running_n = ~running;
         end else if (lap) begin
            if (mode_out == MODE_SW) begin
               if (lap_hold) begin
                  lap_hold_n = 1'b0;
               end else if (running) begin
                  lap_n      = count_bcd;
                  lap_hold_n = 1'b1;
               end
            end
         end
         if (tick) begin
            if (mode_out == MODE_SW) begin
               count_n = inc_v;
               wrap_n  = carry;
            end else if (!is_zero) begin
               count_n = dec_v;
               if (dec_v == '0) begin
                  running_n = 1'b0;
                  done_n    = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_bcd <= '0;
         lap_reg   <= '0;
         running   <= 1'b0;
         mode_out  <= MODE_SW;
         lap_hold  <= 1'b0;
         done      <= 1'b0;
         wrap      <= 1'b0;
      end else begin
         count_bcd <= count_n;
         lap_reg   <= lap_n;
         running   <= running_n;
         mode_out  <= mode_n;
         lap_hold  <= lap_hold_n;
         done      <= done_n;
         wrap      <= wrap_n;
      end
   end

   assign disp = lap_hold ? lap_reg : count_bcd;

   chrono_scan #(
      .ND          (ND),
      .SCAN_DIV    (SCAN_DIV),
      .FRAC_DIGITS (FRAC_DIGITS)
   ) u_scan (
      .clk       (clk),
      .rst_n     (rst_n),
      .disp      (disp),
      .an        (an),
      .digit_bcd (digit_bcd),
      .dp        (dp)
   );

endmodule

// File: tb/tb_bcd_chrono_core.sv
// Directed bench for bcd_chrono_core: DIV=10, ND=5 (M:SS.FF), SCAN_DIV=4.
module tb_bcd_chrono_core;

   localparam logic [4:0] C_CLR  = 5'b10000;
   localparam logic [4:0] C_LD   = 5'b01000;
   localparam logic [4:0] C_MODE = 5'b00100;
   localparam logic [4:0] C_SS   = 5'b00010;
   localparam logic [4:0] C_LAP  = 5'b00001;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_stop, lap, mode, load, clear;
   logic [19:0] load_value;
   logic [19:0] count_bcd;
   logic        running, mode_out, lap_hold, done, wrap;
   logic [4:0]  an;
   logic [3:0]  digit_bcd;
   logic        dp;

   int n_vec = 0;
   int n_err = 0;

   logic [19:0] shown;

   always #5 clk = ~clk;

   bcd_chrono_core #(
      .CLK_HZ      (1000),
      .TICK_HZ     (100),
      .FRAC_DIGITS (2),
      .MIN_DIGITS  (1),
      .SCAN_DIV    (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_stop (start_stop),
      .lap        (lap),
      .mode       (mode),
      .load       (load),
      .clear      (clear),
      .load_value (load_value),
      .count_bcd  (count_bcd),
      .running    (running),
      .mode_out   (mode_out),
      .lap_hold   (lap_hold),
      .done       (done),
      .wrap       (wrap),
      .an         (an),
      .digit_bcd  (digit_bcd),
      .dp         (dp)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Called at a falling edge; the pulse is sampled by the next rising edge.
   task automatic cmd(input logic [4:0] c);
      {clear, load, mode, start_stop, lap} = c;
      @(negedge clk);
      {clear, load, mode, start_stop, lap} = '0;
   endtask

   // Reassemble the displayed value from one full scan cycle.
   task automatic grab(output logic [19:0] v);
      v = '0;
      repeat (20) begin
         @(negedge clk);
         for (int i = 0; i < 5; i++)
            if (an[i] == 1'b0) v[4*i +: 4] = digit_bcd;
      end
   endtask

   initial begin
      logic [4:0] an_exp;
      rst_n = 1'b0;
      {clear, load, mode, start_stop, lap} = '0;
      load_value = '0;
      repeat (3) @(negedge clk);

      // reset values
      chk("rst_count", count_bcd, 20'h0);
      chk("rst_running", running, 1'b0);
      chk("rst_mode", mode_out, 1'b0);
      chk("rst_an", an, 5'b11111);
      chk("rst_dp", dp, 1'b1);
      chk("rst_digit", digit_bcd, 4'h0);

      // scan walk: slot k visible after rising edge 1+4k
      rst_n = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 6; k++) begin
         an_exp = 5'b11111;
         an_exp[k % 5] = 1'b0;
         chk("scan_an", an, an_exp);
         chk("scan_dp", dp, ((k % 5) == 2 || (k % 5) == 4) ? 1'b0 : 1'b1);
         repeat (4) @(negedge clk);
      end

      // stopwatch: first count exactly 10 cycles after running rises
      cmd(C_SS);
      chk("sw_run", running, 1'b1);
      repeat (9) @(negedge clk);
      chk("sw_pre_tick", count_bcd, 20'h0);
      @(negedge clk);
      chk("sw_first_tick", count_bcd, 20'h00001);
      repeat (9990) @(negedge clk);
      chk("sw_1000_ticks", count_bcd, 20'h01000);
      cmd(C_SS);
      chk("sw_stopped", running, 1'b0);
      repeat (30) @(negedge clk);
      chk("sw_hold_stop", count_bcd, 20'h01000);

      // load ignored in stopwatch mode
      load_value = 20'h01111;
      cmd(C_LD);
      chk("sw_load_ign", count_bcd, 20'h01000);

      // lap capture at 0:12.34
      cmd(C_SS);
      repeat (2340) @(negedge clk);
      chk("lap_pre", count_bcd, 20'h01234);
      cmd(C_LAP);
      chk("lap_hold_on", lap_hold, 1'b1);
      grab(shown);
      chk("lap_frozen", shown, 20'h01234);
      chk("lap_live", count_bcd, 20'h01236);
      cmd(C_LAP);
      chk("lap_hold_off", lap_hold, 1'b0);
      cmd(C_SS);
      chk("lap_stop_cnt", count_bcd, 20'h01236);
      grab(shown);
      chk("lap_follow", shown, 20'h01236);
      cmd(C_LAP);
      chk("lap_idle_ign", lap_hold, 1'b0);

      // clear + start_stop on the tick edge
      cmd(C_SS);
      repeat (9) @(negedge clk);
      cmd(C_CLR | C_SS);
      chk("clr_count", count_bcd, 20'h0);
      chk("clr_running", running, 1'b0);
      repeat (20) @(negedge clk);
      chk("clr_no_tick", count_bcd, 20'h0);

      // minute carry 0:59.99 -> 1:00.00
      cmd(C_MODE);
      chk("mode_tmr", mode_out, 1'b1);
      load_value = 20'h05999;
      cmd(C_LD);
      cmd(C_MODE);
      chk("mode_sw", mode_out, 1'b0);
      cmd(C_SS);
      repeat (10) @(negedge clk);
      chk("min_carry", count_bcd, 20'h10000);
      cmd(C_CLR);

      // wrap at 9:59.99
      cmd(C_MODE);
      load_value = 20'h95999;
      cmd(C_LD);
      chk("load_max", count_bcd, 20'h95999);
      cmd(C_MODE);
      cmd(C_SS);
      repeat (9) @(negedge clk);
      chk("wrap_pre", wrap, 1'b0);
      @(negedge clk);
      chk("wrap_count", count_bcd, 20'h0);
      chk("wrap_pulse", wrap, 1'b1);
      chk("wrap_running", running, 1'b1);
      @(negedge clk);
      chk("wrap_end", wrap, 1'b0);
      cmd(C_CLR);

      // timer: clamped load and countdown
      cmd(C_MODE);
      load_value = 20'h07A35;
      cmd(C_LD);
      chk("tmr_clamp", count_bcd, 20'h05935);
      cmd(C_SS);
      repeat (350) @(negedge clk);
      chk("tmr_35", count_bcd, 20'h05900);
      repeat (10) @(negedge clk);
      chk("tmr_borrow", count_bcd, 20'h05899);
      cmd(C_MODE);
      chk("tmr_mode_ign", mode_out, 1'b1);
      cmd(C_SS);
      load_value = 20'h00003;
      cmd(C_LD);
      chk("tmr_reload", count_bcd, 20'h00003);
      cmd(C_SS);
      repeat (29) @(negedge clk);
      chk("tmr_last", count_bcd, 20'h00001);
      chk("tmr_done_pre", done, 1'b0);
      @(negedge clk);
      chk("tmr_zero", count_bcd, 20'h0);
      chk("tmr_done", done, 1'b1);
      chk("tmr_stop", running, 1'b0);
      @(negedge clk);
      chk("tmr_done_end", done, 1'b0);
      cmd(C_SS);
      chk("tmr_start_ign", running, 1'b0);

      // asynchronous reset mid-cycle while running
      cmd(C_MODE);
      cmd(C_SS);
      repeat (25) @(negedge clk);
      chk("arst_pre", count_bcd, 20'h00002);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_an", an, 5'b11111);
      chk("arst_count", count_bcd, 20'h0);
      chk("arst_running", running, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
